// File: rtl/alu_seq_pkg.sv
// Shared constants, opcodes and FSM state type for the ALU issue sequencer.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_NREGS  = 8;
  localparam int SEQ_AW     = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NAND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: writeback port has priority over the host port on
// the same address; three combinational read ports.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_host_en,
  input  logic [AW-1:0]     i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  input  logic [AW-1:0]     i_ra,
  input  logic [AW-1:0]     i_rb,
  input  logic [AW-1:0]     i_rh,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data,
  output logic [DATA_W-1:0] o_rh_data
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_wb_en && (i_wb_addr == AW'(i)))
          r_regs[i] <= i_wb_data;
        else if (i_host_en && (i_host_addr == AW'(i)))
          r_regs[i] <= i_host_data;
      end
    end
  end

  assign o_ra_data = r_regs[i_ra];
  assign o_rb_data = r_regs[i_rb];
  assign o_rh_data = r_regs[i_rh];

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller for the 16-bit combinational ALU: accepts one command,
// drives the ALU from registers, writes the result back and returns it.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds valid and payload stable until that edge.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NREGS  = SEQ_NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_rd,
  input  logic [2:0]        cmd_ra,
  input  logic [2:0]        cmd_rb,
  input  logic              cmd_cin,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              Cin,
  output logic [2:0]        SEL,
  input  logic [DATA_W-1:0] Sum,
  input  logic              Cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic              rsp_zero,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        dbg_state
);

  state_t            r_state, w_state_nxt;
  logic              w_accept, w_wb_en;
  logic [DATA_W-1:0] w_ra_data, w_rb_data;
  logic [DATA_W-1:0] r_a, r_b, r_rsp_data;
  logic [2:0]        r_sel, r_rd;
  logic              r_cin, r_rsp_valid, r_rsp_cout, r_rsp_zero;

  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(SEQ_AW)) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wb_en     (w_wb_en),
    .i_wb_addr   (r_rd),
    .i_wb_data   (Sum),
    .i_host_en   (wr_en),
    .i_host_addr (wr_addr),
    .i_host_data (wr_data),
    .i_ra        (cmd_ra),
    .i_rb        (cmd_rb),
    .i_rh        (rd_addr),
    .o_ra_data   (w_ra_data),
    .o_rb_data   (w_rb_data),
    .o_rh_data   (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wb_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = cmd_valid;
        if (cmd_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_wb_en     = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_cin       <= 1'b0;
      r_rd        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_zero  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_ra_data;
        r_b   <= w_rb_data;
        r_sel <= cmd_op;
        r_cin <= cmd_cin;
        r_rd  <= cmd_rd;
      end
      // Logic ops leave the ALU carry undriven, so it is masked here.
      if (w_wb_en) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= Sum;
        r_rsp_cout  <= r_sel[2] ? 1'b0 : Cout;
        r_rsp_zero  <= (Sum == '0);
      end
      if ((r_state == ST_RESP) && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready = rst_n & (r_state == ST_IDLE);
  assign A         = r_a;
  assign B         = r_b;
  assign SEL       = r_sel;
  assign Cin       = r_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_zero  = r_rsp_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_cin;
  logic [2:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb;
  logic [15:0] A, B, Sum;
  logic        Cin, Cout;
  logic [2:0]  SEL;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_zero;
  logic [15:0] rsp_data;
  logic        wr_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic        force_cout;
  logic [16:0] alu_t;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_cin(cmd_cin),
    .A(A), .B(B), .Cin(Cin), .SEL(SEL), .Sum(Sum), .Cout(Cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // Behavioural ALU; for logic ops the carry is a stub the bench can force.
  always_comb begin
    alu_t = '0;
    Sum   = '0;
    Cout  = 1'b0;
    case (SEL)
      3'b000: alu_t = {1'b0, A} + {1'b0, B} + {16'b0, Cin};
      3'b001: alu_t = {1'b0, A} + 17'd1;
      3'b010: alu_t = {1'b0, A} + {1'b0, ~B} + 17'd1;
      3'b011: alu_t = {1'b0, A} + 17'h0FFFF;
      default: alu_t = '0;
    endcase
    if (SEL[2]) begin
      Cout = force_cout;
      case (SEL)
        3'b100:  Sum = A & B;
        3'b101:  Sum = A | B;
        3'b110:  Sum = A ^ B;
        default: Sum = ~(A & B);
      endcase
    end else begin
      Sum  = alu_t[15:0];
      Cout = alu_t[16];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] addr, input logic [15:0] exp_v);
    rd_addr = addr;
    #1;
    check(tag, {16'b0, rd_data}, {16'b0, exp_v});
  endtask

  // Presents a command in IDLE; returns one step after the accept edge.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb, input logic cin);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_cin = cin;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_chk(input string tag, input logic [15:0] d, input logic c, input logic z);
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_data"},  {16'b0, rsp_data},  {16'b0, d});
    check({tag, "_cout"},  {31'b0, rsp_cout},  {31'b0, c});
    check({tag, "_zero"},  {31'b0, rsp_zero},  {31'b0, z});
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
    cmd_rb = '0; cmd_cin = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; force_cout = 1'b0;

    #2;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_A", {16'b0, A}, 32'd0);
    check("rst_SEL", {29'b0, SEL}, 32'd0);
    reg_chk("rst_r3", 3'd3, 16'h0000);
    #9;
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // ADD R3 = R1 + R2
    @(posedge clk); #1;
    host_write(3'd1, 16'h0005);
    host_write(3'd2, 16'h0003);
    send_cmd(3'b000, 3'd3, 3'd1, 3'd2, 1'b0);
    check("add_A", {16'b0, A}, 32'h5);
    check("add_B", {16'b0, B}, 32'h3);
    check("add_issue_ready", {31'b0, cmd_ready}, 32'd0);
    check("add_issue_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    rsp_chk("add", 16'h0008, 1'b0, 1'b0);
    reg_chk("add_r3", 3'd3, 16'h0008);
    handshake();
    check("add_done_valid", {31'b0, rsp_valid}, 32'd0);
    check("add_done_ready", {31'b0, cmd_ready}, 32'd1);

    // INC wraps to zero with carry
    host_write(3'd1, 16'hFFFF);
    send_cmd(3'b001, 3'd4, 3'd1, 3'd0, 1'b0);
    tick();
    rsp_chk("inc", 16'h0000, 1'b1, 1'b1);
    reg_chk("inc_r4", 3'd4, 16'h0000);
    handshake();

    // NAND with a forced ALU carry must still report cout 0
    host_write(3'd2, 16'hFFFF);
    force_cout = 1'b1;
    send_cmd(3'b111, 3'd5, 3'd1, 3'd2, 1'b0);
    check("nand_SEL", {29'b0, SEL}, 32'd7);
    tick();
    rsp_chk("nand", 16'h0000, 1'b0, 1'b1);
    handshake();
    force_cout = 1'b0;

    // SUB R6 = R3 - R7 under back-pressure; a pending command must wait
    host_write(3'd7, 16'h0002);
    send_cmd(3'b010, 3'd6, 3'd3, 3'd7, 1'b0);
    tick();
    cmd_op = 3'b000; cmd_rd = 3'd0; cmd_ra = 3'd0; cmd_rb = 3'd0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rsp_chk("bp", 16'h0006, 1'b1, 1'b0);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    handshake();
    check("bp_ready_after", {31'b0, cmd_ready}, 32'd1);
    check("bp_state_after", {30'b0, dbg_state}, 32'd0);

    // XOR with a colliding host write on the writeback edge
    send_cmd(3'b110, 3'd2, 3'd7, 3'd3, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    rsp_chk("xor", 16'h000A, 1'b0, 1'b0);
    reg_chk("xor_wb_wins", 3'd2, 16'h000A);
    handshake();

    // OR with a non-colliding host write on the writeback edge
    send_cmd(3'b101, 3'd5, 3'd7, 3'd3, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    reg_chk("or_r5", 3'd5, 16'h000A);
    reg_chk("or_host_r0", 3'd0, 16'hBEEF);
    handshake();

    // Host write on the accept edge is not seen by the operands
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h00F0;
    send_cmd(3'b100, 3'd6, 3'd7, 3'd7, 1'b0);
    wr_en = 1'b0;
    check("and_A_old", {16'b0, A}, 32'h2);
    check("and_B_old", {16'b0, B}, 32'h2);
    tick();
    rsp_chk("and", 16'h0002, 1'b0, 1'b0);
    reg_chk("and_r7_host", 3'd7, 16'h00F0);
    handshake();

    // ra == rb == rd with carry-in
    send_cmd(3'b000, 3'd1, 3'd1, 3'd1, 1'b1);
    check("same_Cin", {31'b0, Cin}, 32'd1);
    tick();
    rsp_chk("same", 16'hFFFF, 1'b1, 1'b0);
    handshake();

    // Reset during ISSUE aborts the operation
    send_cmd(3'b011, 3'd0, 3'd7, 3'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    for (int i = 0; i < 8; i++) reg_chk("mid_rst_reg", 3'(i), 16'h0000);
    cmd_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
      check("mid_rst_valid2", {31'b0, rsp_valid}, 32'd0);
    end
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    check("post_rst_state", {30'b0, dbg_state}, 32'd0);
    check("post_rst_valid", {31'b0, rsp_valid}, 32'd0);

    // DEC after reset works normally
    host_write(3'd7, 16'h0001);
    send_cmd(3'b011, 3'd0, 3'd7, 3'd0, 1'b0);
    tick();
    rsp_chk("dec", 16'h0000, 1'b1, 1'b1);
    handshake();
    check("dec_done_ready", {31'b0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
